// File: rtl/imem_pkg.sv
// Shared FSM state type and default sizing for the instruction fetch unit.
// Optional IMEM_PARITY_EN adds one even-parity bit per stored word.
package imem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DATA_W_DEF    = 64;
  localparam int unsigned ADDR_W_DEF    = 64;
  localparam int unsigned DEPTH_DEF     = 1024;
  localparam int unsigned BYTE_ADDR_DEF = 1;

`ifdef IMEM_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one write port, one synchronous read port.
// Word width includes the parity bit when IMEM_PARITY_EN is defined.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned WORD_W = DATA_W_DEF + PAR_W,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WORD_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // Storage is never reset; the fetch unit clears it with its INIT sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit: zero-fills storage after reset, then serves
// one-cycle-latency fetches and program-load writes. Option: IMEM_PARITY_EN.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned BYTE_ADDR = BYTE_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
`ifdef IMEM_PARITY_EN
  input  logic              prog_par_inv,
`endif
  output logic              init_busy
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned OFF_W  = (BYTE_ADDR != 0) ? $clog2(DATA_W / 8) : 0;
  localparam int unsigned WORD_W = DATA_W + PAR_W;
  localparam logic [ADDR_W-1:0] OFF_MASK = ~({ADDR_W{1'b1}} << OFF_W);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_clr_cnt;
  logic              r_rsp_valid;
  logic              r_addr_err;
  logic              w_init_busy;
  logic              w_run;
  logic              w_req_ok;
  logic              w_prog_ok;
  logic [IDX_W-1:0]  w_req_idx;
  logic [IDX_W-1:0]  w_prog_idx;
  logic              w_accept;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_mem_waddr;
  logic [WORD_W-1:0] w_mem_wdata;
  logic [WORD_W-1:0] w_prog_word;
  logic [WORD_W-1:0] w_mem_rdata;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_par_err;

  // Aligned (when byte-addressed) and within DEPTH words.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ((a & OFF_MASK) == '0) && ((a >> OFF_W) < DEPTH_A);
  endfunction

  assign w_req_ok   = addr_ok(req_addr);
  assign w_prog_ok  = addr_ok(prog_addr);
  assign w_req_idx  = IDX_W'(req_addr >> OFF_W);
  assign w_prog_idx = IDX_W'(prog_addr >> OFF_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == INIT) && (r_clr_cnt == IDX_W'(DEPTH - 1))) begin
      w_state_nxt = RUN;
    end
  end

  always_comb begin
    w_init_busy = 1'b0;
    w_run       = 1'b0;
    if (r_state == INIT) begin
      w_init_busy = 1'b1;
    end else begin
      w_run = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_cnt <= '0;
    end else if (w_init_busy) begin
      r_clr_cnt <= r_clr_cnt + IDX_W'(1);
    end
  end

  // A program write blocks fetch acceptance so the two never share a cycle.
  assign req_ready = w_run && !prog_we && (!r_rsp_valid || rsp_ready);
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_addr_err  <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_addr_err  <= !w_req_ok;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef IMEM_PARITY_EN
  assign w_prog_word = {(^prog_data) ^ prog_par_inv, prog_data};
  assign w_rd_data   = w_mem_rdata[DATA_W-1:0];
  assign w_par_err   = ^w_mem_rdata;
`else
  assign w_prog_word = prog_data;
  assign w_rd_data   = w_mem_rdata;
  assign w_par_err   = 1'b0;
`endif

  // INIT sweep owns the write port; out-of-range program writes are dropped.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = r_clr_cnt;
    w_mem_wdata = '0;
    if (w_init_busy) begin
      w_mem_we = 1'b1;
    end else if (prog_we && w_prog_ok) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = w_prog_idx;
      w_mem_wdata = w_prog_word;
    end
  end

  imem_array #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (w_mem_we),
    .waddr (w_mem_waddr),
    .wdata (w_mem_wdata),
    .re    (w_accept),
    .raddr (w_req_idx),
    .rdata (w_mem_rdata)
  );

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = (r_rsp_valid && !r_addr_err) ? w_rd_data : '0;
  assign rsp_err   = r_rsp_valid && (r_addr_err || w_par_err);
  assign init_busy = w_init_busy;

endmodule
